// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile
// AXI4-Lite slave register file. Each register is a control/config word. All
// of them are exported to the fabric on a flat bus. AW and W may arrive
// independently. A write commits on the first edge where both are present.
// Indices beyond NUM_REGS complete with SLVERR and do not change any register.
// The read channel is independent of the write channel and holds its response
// under rready backpressure.
module axi_lite_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // write address channel
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  // write data channel
  input  logic                           wvalid,
  output logic                           wready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  // write response channel
  output logic                           bvalid,
  input  logic                           bready,
  output logic [1:0]                     bresp,
  // read address channel
  input  logic                           arvalid,
  output logic                           arready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  // read data channel
  output logic                           rvalid,
  input  logic                           rready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  // register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // The register count is held one bit wider than the index. This lets
  // NUM_REGS == 2**ADDR_WIDTH compare cleanly.
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wstate_t;

  wstate_t state_reg, state_next;

  // AW/W holding registers and capture flags
  logic                  aw_captured_reg;
  logic                  w_captured_reg;
  logic [ADDR_WIDTH-1:0] aw_addr_reg;
  logic [DATA_WIDTH-1:0] w_data_reg;
  logic [STRB_WIDTH-1:0] w_strb_reg;
  logic [1:0]            bresp_reg;

  // read channel state
  logic                  rvalid_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]            rresp_reg;

  // effective write operands: take the live bus when the handshake is on the
  // commit edge itself, otherwise the held copy
  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic                  wr_in_range;

  logic                  ar_in_range;
  logic [DATA_WIDTH-1:0] rd_mux;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  assign wr_addr = aw_captured_reg ? aw_addr_reg : awaddr;
  assign wr_data = w_captured_reg  ? w_data_reg  : wdata;
  assign wr_strb = w_captured_reg  ? w_strb_reg  : wstrb;

  assign wr_in_range = ({1'b0, wr_addr} < NUM_REGS_W);
  assign ar_in_range = ({1'b0, araddr} < NUM_REGS_W);

  // write FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= W_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // write FSM next state, channel readies and commit strobe
  always_comb begin
    state_next = state_reg;
    awready    = 1'b0;
    wready     = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      W_IDLE: begin
        awready = !aw_captured_reg;
        wready  = !w_captured_reg;
        if ((aw_captured_reg || awvalid) && (w_captured_reg || wvalid)) begin
          commit     = 1'b1;
          state_next = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) begin
          state_next = W_IDLE;
        end
      end
      default: begin
        state_next = W_IDLE;
      end
    endcase
  end

  // capture AW and W as they arrive and release both on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_captured_reg <= 1'b0;
      w_captured_reg  <= 1'b0;
      aw_addr_reg     <= '0;
      w_data_reg      <= '0;
      w_strb_reg      <= '0;
    end else if (commit) begin
      aw_captured_reg <= 1'b0;
      w_captured_reg  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_captured_reg <= 1'b1;
        aw_addr_reg     <= awaddr;
      end
      if (w_hs) begin
        w_captured_reg <= 1'b1;
        w_data_reg     <= wdata;
        w_strb_reg     <= wstrb;
      end
    end
  end

  // write response code, latched on commit and held through W_RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bresp_reg <= RESP_OKAY;
    end else if (commit) begin
      bresp_reg <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign bvalid = (state_reg == W_RESP);
  assign bresp  = bresp_reg;

  // one storage word per register with byte-lane write enables
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(gi);

    logic [DATA_WIDTH-1:0] value_reg;
    logic                  wr_sel;

    assign wr_sel = commit && (wr_addr == IDX);

    // update only the strobed byte lanes of this register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        value_reg <= '0;
      end else if (wr_sel) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (wr_strb[b]) begin
            value_reg[b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end

    assign regs_out[gi*DATA_WIDTH +: DATA_WIDTH] = value_reg;
  end

  // read mux over the exported bus. Unmatched indices read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (araddr == ADDR_WIDTH'(i)) begin
        rd_mux = regs_out[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // read channel: accept only when no response is pending.
  // Hold the response until rready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else if (!rvalid_reg) begin
      if (arvalid) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= ar_in_range ? rd_mux : '0;
        rresp_reg  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end else if (rready) begin
      rvalid_reg <= 1'b0;
    end
  end

  assign arready = !rvalid_reg;
  assign rvalid  = rvalid_reg;
  assign rdata   = rdata_reg;
  assign rresp   = rresp_reg;

endmodule
